// File: rtl/dmem_loader_pkg.sv
// Shared definitions for the data-memory loader: FSM states and default
// memory geometry used by the memory stage.
package dmem_loader_pkg;

    localparam int unsigned ADDR_W_DEF = 7;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/dmem_loader_byte_packer.sv
// Byte packer: assembles four bytes little-endian into a 32-bit word.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   clr          - clear byte counter and word buffer
//   load_en      - shift byte_in into the word buffer this cycle
//   byte_in      - incoming byte
//   full_c       - three bytes held; the next load completes the word
//   word_nxt_c   - word buffer value after loading byte_in
module dmem_loader_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        load_en,
    input  logic [7:0]  byte_in,
    output logic        full_c,
    output logic [31:0] word_nxt_c
);

    logic [1:0]  cnt_q,  cnt_d;
    logic [31:0] word_q, word_d;

    // Shifting in at the top leaves byte 0 in bits [7:0] after four loads.
    assign word_nxt_c = {byte_in, word_q[31:8]};
    assign full_c     = (cnt_q == 2'd3);

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clr) begin
            cnt_d  = 2'd0;
            word_d = 32'd0;
        end else if (load_en) begin
            cnt_d  = cnt_q + 2'd1;
            word_d = word_nxt_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            word_q <= 32'd0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/dmem_loader.sv
// Data-memory loader: receives a byte stream, packs it into words and writes
// them to consecutive (wrapping) data-memory addresses.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   start, base_addr, word_len - load request (sampled in IDLE only)
//   byte_data, byte_valid, byte_ready - byte stream handshake
//   mem_a, mem_d, mem_we     - data-memory write port
//   busy                     - loader owns the memory port
//   done                     - one-cycle completion pulse
//   words_written            - words written by the current/last load
module dmem_loader
    import dmem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_len,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q,  base_d;
    logic [LEN_W-1:0]    len_q,   len_d;
    logic [LEN_W-1:0]    ww_q,    ww_d;
    logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
    logic [DATA_W-1:0]   mem_d_q, mem_d_d;
    logic                byte_ready_q, mem_we_q, busy_q, done_q;
    logic [LEN_W-1:0]    ww_inc;

    logic                pk_clr;
    logic                pk_load;
    logic                pk_full_c;
    logic [31:0]         pk_word_nxt_c;

    dmem_loader_byte_packer u_byte_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (pk_clr),
        .load_en    (pk_load),
        .byte_in    (byte_data),
        .full_c     (pk_full_c),
        .word_nxt_c (pk_word_nxt_c)
    );

    assign ww_inc = ww_q + LEN_W'(1);

    // Next-state logic; write address/data are captured on the edge that
    // accepts the 4th byte so they are stable throughout the WRITE cycle.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        ww_d    = ww_q;
        mem_a_d = mem_a_q;
        mem_d_d = mem_d_q;
        pk_clr  = 1'b0;
        pk_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    len_d   = word_len;
                    ww_d    = '0;
                    pk_clr  = 1'b1;
                    state_d = (word_len == '0) ? ST_DONE : ST_RECV;
                end
            end
            ST_RECV: begin
                if (byte_valid) begin
                    pk_load = 1'b1;
                    if (pk_full_c) begin
                        state_d = ST_WRITE;
                        mem_a_d = base_q + ww_q[ADDR_W-1:0];
                        mem_d_d = DATA_W'(pk_word_nxt_c);
                    end
                end
            end
            ST_WRITE: begin
                ww_d    = ww_inc;
                pk_clr  = 1'b1;
                state_d = (ww_inc == len_q) ? ST_DONE : ST_RECV;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            len_q        <= '0;
            ww_q         <= '0;
            mem_a_q      <= '0;
            mem_d_q      <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            len_q        <= len_d;
            ww_q         <= ww_d;
            mem_a_q      <= mem_a_d;
            mem_d_q      <= mem_d_d;
            byte_ready_q <= (state_d == ST_RECV);
            mem_we_q     <= (state_d == ST_WRITE);
            busy_q       <= (state_d != ST_IDLE);
            done_q       <= (state_d == ST_DONE);
        end
    end

    assign byte_ready    = byte_ready_q;
    assign mem_a         = mem_a_q;
    assign mem_d         = mem_d_q;
    assign mem_we        = mem_we_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign words_written = ww_q;

endmodule

// File: tb/tb_dmem_loader.sv
// Self-checking bench for dmem_loader: randomized byte streams checked
// against an expected-write queue built from the load parameters.
module tb_dmem_loader;

    localparam int AW = 7;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   word_len = '0;
    logic [7:0]    byte_data = '0;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d;
    logic          mem_we;
    logic          busy;
    logic          done;
    logic [AW:0]   words_written;

    dmem_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .word_len      (word_len),
        .byte_data     (byte_data),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .mem_a         (mem_a),
        .mem_d         (mem_d),
        .mem_we        (mem_we),
        .busy          (busy),
        .done          (done),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]    stim[$];
    logic [AW-1:0] exp_a[$];
    logic [DW-1:0] exp_d[$];
    int            done_cnt = 0;
    int            we_cnt   = 0;
    int            rdy_cnt  = 0;
    int            cur_len  = 0;
    logic          in_load  = 1'b0;
    logic          prev_we  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int nbytes);
        stim.delete();
        for (int i = 0; i < nbytes; i++) stim.push_back(8'($urandom));
    endtask

    // Monitor: every write must match the next expected (address, word).
    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt++;
            if (exp_a.size() == 0) begin
                chk("unexp_we", 64'(mem_we), 64'(0));
            end else begin
                chk("mem_a", 64'(mem_a), 64'(exp_a.pop_front()));
                chk("mem_d", 64'(mem_d), 64'(exp_d.pop_front()));
            end
        end
        if (byte_ready) rdy_cnt++;
        if (done) begin
            done_cnt++;
            chk("done_after_we", 64'(prev_we), 64'(cur_len != 0));
        end
        if (in_load) chk("busy", 64'(busy), 64'(1));
        prev_we = mem_we;
    end

    // One load: expected writes are derived from base/len/bytes alone.
    task automatic do_load(input int base, input int len, input int vpct,
                           input int glitch_at, input int rst_at);
        int   idx;
        int   cyc;
        int   d0;
        logic hs;
        cur_len = len;
        for (int w = 0; w < len; w++) begin
            exp_a.push_back(AW'((base + w) % (1 << AW)));
            exp_d.push_back({stim[4*w+3], stim[4*w+2], stim[4*w+1], stim[4*w]});
        end
        start     = 1'b1;
        base_addr = AW'(base);
        word_len  = (AW+1)'(len);
        d0        = done_cnt;
        tick();
        start   = 1'b0;
        in_load = 1'b1;
        idx = 0;
        cyc = 0;
        while (idx < 4*len && cyc < 20000) begin
            if (idx == rst_at) begin
                rst        = 1'b1;
                byte_valid = 1'b0;
                tick();
                rst     = 1'b0;
                in_load = 1'b0;
                exp_a.delete();
                exp_d.delete();
                chk("rst_busy", 64'(busy), 64'(0));
                chk("rst_we", 64'(mem_we), 64'(0));
                return;
            end
            start = (idx == glitch_at);
            if (start) begin
                base_addr = AW'(99);
                word_len  = (AW+1)'(7);
            end
            byte_valid = ($urandom_range(99) < vpct);
            byte_data  = byte_valid ? stim[idx] : 8'($urandom);
            hs         = byte_valid && byte_ready;
            tick();
            cyc++;
            if (hs) idx++;
        end
        start      = 1'b0;
        byte_valid = 1'b0;
        chk("bytes_taken", 64'(idx), 64'(4*len));
        for (int c = 0; c < 20 && done_cnt == d0; c++) tick();
        in_load = 1'b0;
        chk("done_seen", 64'(done_cnt - d0), 64'(1));
        chk("words_written", 64'(words_written), 64'(len));
        chk("writes_left", 64'(exp_a.size()), 64'(0));
        repeat (3) tick();
        chk("done_once", 64'(done_cnt - d0), 64'(1));
        chk("ww_hold", 64'(words_written), 64'(len));
    endtask

    initial begin
        int r0;
        int w0;
        logic [AW-1:0] last_a;

        repeat (3) tick();
        rst = 1'b0;
        chk("rst_ready", 64'(byte_ready), 64'(0));
        chk("rst_we",    64'(mem_we), 64'(0));
        chk("rst_a",     64'(mem_a), 64'(0));
        chk("rst_d",     64'(mem_d), 64'(0));
        chk("rst_busy",  64'(busy), 64'(0));
        chk("rst_done",  64'(done), 64'(0));
        chk("rst_ww",    64'(words_written), 64'(0));

        // Single word, back-to-back bytes.
        stim.delete();
        stim.push_back(8'h78); stim.push_back(8'h56);
        stim.push_back(8'h34); stim.push_back(8'h12);
        w0 = we_cnt;
        do_load(5, 1, 100, -1, -1);
        chk("single_we_cnt", 64'(we_cnt - w0), 64'(1));
        chk("single_d", 64'(mem_d), 64'(32'h1234_5678));

        // Wrap across the top of the address space.
        fill(12);
        do_load(126, 3, 100, -1, -1);
        last_a = mem_a;
        tick();
        chk("mem_a_hold", 64'(mem_a), 64'(last_a));

        // Zero-length load.
        r0 = rdy_cnt;
        w0 = we_cnt;
        stim.delete();
        do_load(20, 0, 100, -1, -1);
        chk("len0_rdy", 64'(rdy_cnt - r0), 64'(0));
        chk("len0_we",  64'(we_cnt - w0), 64'(0));

        // Random valid gaps across two words.
        fill(8);
        do_load(60, 2, 50, -1, -1);

        // Reset after two bytes, then a fresh load.
        fill(8);
        w0 = we_cnt;
        do_load(10, 2, 100, -1, 2);
        tick();
        chk("rst_mid_we_cnt", 64'(we_cnt - w0), 64'(0));
        chk("rst_mid_ww", 64'(words_written), 64'(0));
        fill(8);
        do_load(10, 2, 70, -1, -1);

        // Start pulses while receiving must be ignored.
        fill(8);
        do_load(40, 2, 80, 2, -1);

        // Random loads, including one longer than the address space.
        for (int t = 0; t < 4; t++) begin
            int len;
            len = $urandom_range(1, 5);
            fill(4*len);
            do_load($urandom_range(0, 127), len, $urandom_range(30, 100), -1, -1);
        end
        fill(4*130);
        do_load($urandom_range(0, 127), 130, 90, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_loader.md
DMEM_LOADER -- requirements
Module: dmem_loader

Interface
REQ-001 Parameter ADDR_W, default 7, data-memory word-address width.
REQ-002 Parameter DATA_W, default 32, data-memory word width; fixed at 4 bytes.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 start  in  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 base_addr  in  ADDR_W  first word address; captured on accepted start.
REQ-007 word_len  in  ADDR_W+1  number of words to load; captured on accepted start.
REQ-008 byte_data  in  8  incoming byte stream.
REQ-009 byte_valid  in  1  byte_data is valid.
REQ-010 byte_ready  out  1  loader accepts a byte this cycle.
REQ-011 mem_a  out  ADDR_W  data-memory word address.
REQ-012 mem_d  out  DATA_W  data-memory write data.
REQ-013 mem_we  out  1  data-memory write enable.
REQ-014 busy  out  1  loader owns the data-memory port; pipeline stalls and the memory address mux selects mem_a.
REQ-015 done  out  1  one-cycle pulse at load completion.
REQ-016 words_written  out  ADDR_W+1  words written in the current/last load.

Function
REQ-017 FSM states: IDLE, RECV, WRITE, DONE.
REQ-018 IDLE: start=1 -> capture base_addr and word_len, clear words_written and the byte counter, and go to RECV; if captured word_len=0, go directly to DONE.
REQ-019 A byte transfer occurs when byte_valid and byte_ready are both 1 on the same edge; byte_ready=1 only in RECV.
REQ-020 Packing is little-endian: byte k (k=0..3) of a word goes to bits [8k+7:8k].
REQ-021 Acceptance of the 4th byte -> WRITE on the next cycle.
REQ-022 WRITE lasts exactly one cycle with mem_we=1, mem_a=(base_addr+words_written) mod 2^ADDR_W, and mem_d=assembled word.
REQ-023 WRITE exit: increment words_written; if the new value equals word_len, go to DONE, otherwise go to RECV with the byte counter cleared.
REQ-024 Sustained throughput is 5 cycles per word (4 byte cycles plus 1 write bubble).
REQ-025 DONE lasts one cycle with done=1, then returns to IDLE.
REQ-026 busy=1 in RECV, WRITE and DONE; busy=0 in IDLE.
REQ-027 mem_we=0 outside WRITE; mem_a and mem_d are don't-care while mem_we=0 but hold their last values.
REQ-028 start is ignored outside IDLE.
REQ-029 byte_valid=0 in RECV holds state indefinitely with no timeout.
REQ-030 Address wrap: base_addr+idx wraps modulo 2^ADDR_W with no error.
REQ-031 word_len above 2^ADDR_W is legal; later words overwrite wrapped addresses.
REQ-032 words_written holds its final value in IDLE until the next accepted start.

Reset
REQ-033 rst=1 on an edge -> state IDLE; byte counter, word buffer and words_written cleared to 0.
REQ-034 Output reset values: byte_ready=0, mem_we=0, mem_a=0, mem_d=0, busy=0, done=0.
REQ-035 Reset mid-load discards any partial word; no write is issued in the reset cycle or after it.

Structure
REQ-036 A shared package holds the FSM state enumeration and the ADDR_W and DATA_W defaults used by the memory stage.
REQ-037 One sub-module, byte_packer, owns the 2-bit byte counter and the 32-bit shift/assemble register, with clear, load-enable and full outputs.

Verification
REQ-038 base_addr=5, word_len=1, bytes 0x78,0x56,0x34,0x12 back-to-back -> single mem_we pulse, mem_a=5, mem_d=0x12345678, done 1 cycle later, words_written=1.
REQ-039 base_addr=126, word_len=3, 12 bytes -> writes at addresses 126, 127, 0, in order; busy high throughout; done once.
REQ-040 word_len=0 with start -> DONE the next cycle, done pulse, no mem_we, byte_ready never 1.
REQ-041 byte_valid toggled randomly across a 2-word load -> only handshaken bytes are packed; mem_d values match the expected little-endian words.
REQ-042 rst asserted after 2 bytes of a word -> no mem_we, busy=0 next cycle; a fresh load afterwards writes correct data.
REQ-043 start pulsed during RECV -> ignored; base_addr and word_len of the active load are unchanged.
